// File: rtl/sync_frame_arbiter_if.sv
// Stream bundle around the arbiter: NUM_CH scrambler byte streams in, one framer stream out.
// master = arbiter side (drives the framer stream and per-channel ready); slave = surrounding logic.
interface sync_frame_arbiter_if #(
  parameter int NUM_CH = 4
);
  logic [8*NUM_CH-1:0] s_axis_tdata;
  logic [NUM_CH-1:0]   s_axis_tvalid;
  logic [NUM_CH-1:0]   s_axis_tready;
  logic [7:0]          m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic                m_axis_tlast;
  logic [2:0]          m_axis_tuser;

  modport master (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast,
    output m_axis_tuser
  );

  modport slave (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast,
    input  m_axis_tuser
  );
endinterface

// File: rtl/sync_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing the Sync framer among NUM_CH byte streams.
// Define SYNC_ARB_TIMEOUT_EN to add the stall timeout that zero-pads a starved frame.
module sync_frame_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int PAYLOAD_LEN = 255,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 core_clk,
  input  logic                 rst_n,
  sync_frame_arbiter_if.master axis,
  output logic [NUM_CH-1:0]    grant,
  output logic                 busy,
  output logic                 err_pad,
  input  logic                 err_clr
);

  localparam logic [8:0]        LAST_CNT = 9'(PAYLOAD_LEN - 1);
  localparam logic [2:0]        PTR_RST  = 3'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ONE      = NUM_CH'(1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    PAD
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [2:0]        gidx_q, gidx_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [7:0]        tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [2:0]        tuser_q, tuser_d;

  logic              out_rdy;
  logic              fire;
  logic              last_beat;
  logic              g_valid;
  logic [7:0]        g_data;
  logic              load_en;
  logic [7:0]        load_data;
  logic [NUM_CH-1:0] s_rdy;

  logic              sel_any;
  logic [NUM_CH-1:0] sel_oh;
  logic [2:0]        sel_idx;
  int unsigned       rr;

`ifdef SYNC_ARB_TIMEOUT_EN
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] stall_q, stall_d;
  logic        err_q, err_d;
`else
  logic unused_cfg;
  assign unused_cfg = err_clr ^ TIMEOUT_CYC[0];
`endif

  assign out_rdy   = !tvalid_q || axis.m_axis_tready;
  assign fire      = tvalid_q && axis.m_axis_tready;
  assign last_beat = (cnt_q == LAST_CNT);

  // Round-robin search upward from ptr+1, wrapping; the first live requester wins.
  always_comb begin
    sel_any = 1'b0;
    sel_oh  = '0;
    sel_idx = '0;
    rr      = 0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      rr = ({29'd0, ptr_q} + i) % NUM_CH;
      if (!sel_any && |(axis.s_axis_tvalid & (ONE << rr))) begin
        sel_any = 1'b1;
        sel_oh  = ONE << rr;
        sel_idx = 3'(rr);
      end
    end
  end

  always_comb begin
    g_valid = |(axis.s_axis_tvalid & grant_q);
    g_data  = '0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (|(grant_q & (ONE << j))) begin
        g_data = g_data | 8'(axis.s_axis_tdata >> (8 * j));
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tuser_d   = tuser_q;
    s_rdy     = '0;
    load_en   = 1'b0;
    load_data = '0;
`ifdef SYNC_ARB_TIMEOUT_EN
    stall_d   = stall_q;
    err_d     = err_clr ? 1'b0 : err_q;
`endif

    if (fire) begin
      tvalid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (sel_any) begin
          grant_d = sel_oh;
          gidx_d  = sel_idx;
          state_d = XFER;
        end
      end
      XFER: begin
        s_rdy     = grant_q & {NUM_CH{out_rdy}};
        load_en   = out_rdy && g_valid;
        load_data = g_data;
`ifdef SYNC_ARB_TIMEOUT_EN
        if (load_en) begin
          stall_d = '0;
        end else if (out_rdy) begin
          stall_d = stall_q + 16'd1;
          if (stall_q == STALL_LAST) begin
            stall_d = '0;
            state_d = PAD;
            err_d   = 1'b1;
          end
        end
`endif
      end
`ifdef SYNC_ARB_TIMEOUT_EN
      PAD: begin
        load_en   = out_rdy;
        load_data = '0;
      end
`endif
      default: ;
    endcase

    // Data and pad beats share one load path so tlast/tuser/byte_cnt stay consistent.
    if (load_en) begin
      tdata_d  = load_data;
      tvalid_d = 1'b1;
      tlast_d  = last_beat;
      tuser_d  = gidx_q;
      cnt_d    = cnt_q + 9'd1;
      if (last_beat) begin
        state_d = IDLE;
        ptr_d   = gidx_q;
        cnt_d   = '0;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      ptr_q    <= PTR_RST;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
    end
  end

`ifdef SYNC_ARB_TIMEOUT_EN
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err_pad = err_q;
`else
  assign err_pad = 1'b0;
`endif

  assign axis.s_axis_tready = s_rdy;
  assign axis.m_axis_tdata  = tdata_q;
  assign axis.m_axis_tvalid = tvalid_q;
  assign axis.m_axis_tlast  = tlast_q;
  assign axis.m_axis_tuser  = tuser_q;
  assign grant              = grant_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_sync_frame_arbiter.sv
// Scoreboard bench for sync_frame_arbiter: directed frames pushed as expected beats, monitor pops on fire.
module tb_sync_frame_arbiter;
  localparam int NUM_CH = 4;
  localparam int PL     = 255;
  localparam logic [NUM_CH-1:0] ONE_CH = NUM_CH'(1);

  logic              clk;
  logic              rst_n;
  logic              err_clr;
  logic [NUM_CH-1:0] grant;
  logic              busy;
  logic              err_pad;

  sync_frame_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

  sync_frame_arbiter #(
    .NUM_CH     (NUM_CH),
    .PAYLOAD_LEN(PL),
    .TIMEOUT_CYC(16)
  ) dut (
    .core_clk(clk),
    .rst_n   (rst_n),
    .axis    (bus.master),
    .grant   (grant),
    .busy    (busy),
    .err_pad (err_pad),
    .err_clr (err_clr)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [2:0] user;
  } beat_t;

  beat_t             exp_q[$];
  int                last_cyc[$];
  int                seq[$]   = '{0, 0, 0, 0};
  int                limit[$] = '{0, 0, 0, 0};
  logic [NUM_CH-1:0] en;
  bit                rand_rdy;
  int                checks;
  int                failures;
  int                cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] src_byte(input int ch, input int s);
    return 8'(s * 3 + ch * 50 + 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // n_data source bytes starting at first_seq, then zero padding up to PL beats.
  task automatic push_frame(input int ch, input int first_seq, input int n_data);
    beat_t b;
    for (int k = 0; k < PL; k++) begin
      b.data = (k < n_data) ? src_byte(ch, first_seq + k) : 8'h00;
      b.last = (k == PL - 1);
      b.user = 3'(ch);
      exp_q.push_back(b);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grant"},   32'(grant), 0);
    chk({tag, "_busy"},    32'(busy), 0);
    chk({tag, "_tvalid"},  32'(bus.m_axis_tvalid), 0);
    chk({tag, "_tdata"},   32'(bus.m_axis_tdata), 0);
    chk({tag, "_tlast"},   32'(bus.m_axis_tlast), 0);
    chk({tag, "_tuser"},   32'(bus.m_axis_tuser), 0);
    chk({tag, "_s_ready"}, 32'(bus.s_axis_tready), 0);
    chk({tag, "_err_pad"}, 32'(err_pad), 0);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int k = 0;
    while (exp_q.size() != 0 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(exp_q.size()), 0);
  endtask

  task automatic wait_seq(input string name, input int ch, input int target);
    int k = 0;
    while (seq[ch] < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(seq[ch] >= target), 1);
  endtask

  task automatic do_reset();
    en       = '0;
    rand_rdy = 0;
    err_clr  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    last_cyc.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Source model: each channel emits its own byte sequence, advancing only on accept.
  initial begin : driver
    logic [NUM_CH-1:0]   acc;
    logic [NUM_CH-1:0]   v;
    logic [8*NUM_CH-1:0] d;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      acc = bus.s_axis_tready & bus.s_axis_tvalid;
      @(posedge clk);
      #1;
      v = '0;
      d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (!rst_n) seq[c] = 0;
        else if (|(acc & (ONE_CH << c))) seq[c] = seq[c] + 1;
        if (|(en & (ONE_CH << c)) && seq[c] < limit[c]) v = v | (ONE_CH << c);
        d = d | ((8 * NUM_CH)'(src_byte(c, seq[c])) << (8 * c));
      end
      bus.s_axis_tvalid = v;
      bus.s_axis_tdata  = d;
      bus.m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    logic [11:0] act;
    beat_t       b;
    forever begin
      @(negedge clk);
      if (rst_n && bus.m_axis_tvalid) begin
        act = {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser};
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected got=0x%0h required=no_beat (t=%0t)", act, $time);
        end else if (bus.m_axis_tready) begin
          b = exp_q.pop_front();
          chk("out_beat", 32'(act), 32'(b));
          if (bus.m_axis_tlast) last_cyc.push_back(cyc);
        end else begin
          chk("out_hold", 32'(act), 32'(exp_q[0]));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : control
    int viol;
    int cnt;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    err_clr  = 1'b0;
    en       = '0;
    rand_rdy = 0;
    #2 rst_n = 1'b0;
    #1 check_zero("rst_async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("rst_release");

    // All channels streaming: rotation 0,1,2,3,0 with 256-cycle frame spacing.
    for (int c = 0; c < NUM_CH; c++) limit[c] = 255;
    limit[0] = 510;
    push_frame(0, 0, 255);
    push_frame(1, 0, 255);
    push_frame(2, 0, 255);
    push_frame(3, 0, 255);
    push_frame(0, 255, 255);
    en = '1;
    @(negedge clk);
    chk("t1_idle_grant", 32'(grant), 0);
    @(negedge clk);
    chk("t1_grant_ch0", 32'(grant), 32'(4'b0001));
    chk("t1_busy", 32'(busy), 1);
    chk("t1_tvalid_lat", 32'(bus.m_axis_tvalid), 0);
    chk("t1_s_ready", 32'(bus.s_axis_tready), 32'(4'b0001));
    @(negedge clk);
    chk("t1_tvalid_first", 32'(bus.m_axis_tvalid), 1);
    wait_drain("t1_drain", 3000);
    chk("t1_frames", 32'(last_cyc.size()), 5);
    for (int k = 1; k < last_cyc.size(); k++)
      chk("t1_frame_period", 32'(last_cyc[k] - last_cyc[k-1]), 256);

    // ch2 alone, ch1 joins mid-frame and must wait for the frame boundary.
    do_reset();
    for (int c = 0; c < NUM_CH; c++) limit[c] = 255;
    push_frame(2, 0, 255);
    push_frame(1, 0, 255);
    en   = 4'b0100;
    viol = 0;
    for (int k = 0; k < 2000 && exp_q.size() > PL; k++) begin
      @(negedge clk);
      if (seq[2] >= 100) en[1] = 1'b1;
      if (bus.s_axis_tready[1] && !grant[1]) viol++;
      if (grant[1] && bus.s_axis_tready[2]) viol++;
    end
    chk("t2_ch1_ready_low", 32'(viol), 0);
    wait_drain("t2_drain", 1500);

    // Random back-pressure: held beats must match the pending expected beat.
    do_reset();
    for (int c = 0; c < NUM_CH; c++) limit[c] = 255;
    push_frame(0, 0, 255);
    push_frame(1, 0, 255);
    push_frame(2, 0, 255);
    push_frame(3, 0, 255);
    rand_rdy = 1;
    en       = '1;
    wait_drain("t3_drain", 8000);
    rand_rdy = 0;

    // ch0 starves after 100 bytes.
    do_reset();
    limit[0] = 100;
    en       = 4'b0001;
`ifdef SYNC_ARB_TIMEOUT_EN
    push_frame(0, 0, 100);
    err_clr = 1'b1;
    wait_seq("t4_seq100", 0, 100);
    cnt = 0;
    while (!err_pad && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    err_clr = 1'b0;
    chk("t4_stall_to_pad", 32'(cnt), 16);
    chk("t4_pad_s_ready", 32'(bus.s_axis_tready), 0);
    wait_drain("t4_pad_drain", 1000);
    chk("t4_err_sticky", 32'(err_pad), 1);
    chk("t4_idle_after_pad", 32'(busy), 0);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t4_err_cleared", 32'(err_pad), 0);
`else
    push_frame(0, 0, 255);
    wait_seq("t4_seq100", 0, 100);
    repeat (250) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (249) @(negedge clk);
    chk("t4_grant_held", 32'(grant), 32'(4'b0001));
    chk("t4_busy_held", 32'(busy), 1);
    chk("t4_no_pad", 32'(exp_q.size()), 155);
    chk("t4_err_tied", 32'(err_pad), 0);
    limit[0] = 255;
    wait_drain("t4_resume_drain", 1000);
    chk("t4_grant_released", 32'(grant), 0);
`endif

    // Reset mid-frame on ch1; afterwards ch0 wins and byte count restarts.
    do_reset();
    limit[0] = 255;
    limit[1] = 255;
    push_frame(1, 0, 255);
    en = 4'b0010;
    wait_seq("t5_seq40", 1, 40);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("t5_async");
    exp_q.delete();
    en = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("t5_release");
    push_frame(0, 0, 255);
    push_frame(1, 0, 255);
    en = 4'b0011;
    wait_drain("t5_drain", 1500);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_frame_arbiter.md
# sync_frame_arbiter

Frame-granular round-robin arbiter that shares the single `Sync` framer among `NUM_CH` scrambler output streams. Once a channel is granted, it owns the framer input for exactly `PAYLOAD_LEN` bytes. This keeps every framer payload from a single source and frame-aligned. The block sits between the per-channel scramblers and the `Sync` input, and tags each frame with its channel ID.

## Interface
- `NUM_CH`, 4: number of requesting byte streams (2..8).
- `PAYLOAD_LEN`, 255: bytes per granted frame; must equal the framer payload length (1..256).
- `TIMEOUT_CYC`, 1024: stall cycles before forced padding (used only with the macro); range 2..65535.
- `core_clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in `8*NUM_CH`: channel i data in bits `[8i+7:8i]`.
- `s_axis_tvalid` in `NUM_CH`: per-channel valid.
- `s_axis_tready` out `NUM_CH`: per-channel ready; at most one bit is high.
- `m_axis_tdata` out 8: byte to the framer.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: framer ready.
- `m_axis_tlast` out 1: high on byte `PAYLOAD_LEN-1` of each frame.
- `m_axis_tuser` out 3: channel ID of the current byte.
- `grant` out `NUM_CH`: one-hot owner; zero when idle.
- `busy` out 1: high when the FSM is not IDLE.
- `err_pad` out 1: sticky flag for a timeout pad event.
- `err_clr` in 1: synchronous clear of `err_pad`.

## Operation
- FSM states: IDLE, XFER, PAD.
- Reset values: all outputs 0, FSM in IDLE, RR pointer `NUM_CH-1`, so ch0 has first priority.
- IDLE:
  - All `s_axis_tready` are 0.
  - If any `s_axis_tvalid` is high, pick the first requester searching upward from pointer+1, with wrap.
  - Register `grant` and go to XFER next cycle.
- XFER:
  - `s_axis_tready[g] = !m_axis_tvalid || m_axis_tready`; all other ready bits stay 0.
  - Each accepted byte loads the output register: data, valid=1, tuser=g, tlast=(byte_cnt==`PAYLOAD_LEN-1`). It also increments byte_cnt (9 bits).
  - On accepting byte `PAYLOAD_LEN-1`: go to IDLE, set pointer=g, clear byte_cnt and grant.
- Stall counter (16 bits):
  - Increments each XFER cycle where `s_axis_tready[g]` is high and `s_axis_tvalid[g]` is low.
  - Clears on any accept and on state exit.
- PAD (macro only):
  - Entered when the stall counter reaches `TIMEOUT_CYC-1`.
  - `s_axis_tready` is all 0; emits 0x00 with tuser=g until byte `PAYLOAD_LEN-1` (tlast) is loaded.
  - Sets `err_pad` on entry, then goes to IDLE.
- Output register: `m_axis_tvalid` drops on fire unless a new byte loads in the same cycle. Data must not change while valid is high and ready is low.
- `err_pad`: if set and `err_clr` occur in the same cycle, set wins.
- A deasserted requester is never granted. A request that drops after grant does not release the grant.
- Reset mid-frame: the frame is abandoned and the output is cleared immediately. The framer must be reset together with this block.

## Timing
- Arbitration: 1 cycle. A request seen in IDLE at cycle N gives grant at N+1, first accept at N+1, and first `m_axis_tvalid` at N+2.
- Datapath latency: 1 cycle from input accept to output valid.
- Steady state with everything ready: 1 byte/cycle, `PAYLOAD_LEN+1` cycles per frame (one IDLE cycle between frames).
- Back-pressure: a `m_axis_tready` low stalls the input the same cycle, via the combinational ready path.
- Timeout: PAD is entered on the cycle after the `TIMEOUT_CYC`-th consecutive stall cycle.

## Configuration
- `SYNC_ARB_TIMEOUT_EN` defined:
  - Stall counter, PAD state and `err_pad` logic are present.
  - A starved channel cannot block the framer longer than `TIMEOUT_CYC` cycles plus the remaining pad bytes.
- Undefined:
  - No PAD state; XFER waits indefinitely on the granted channel.
  - `err_pad` is tied to 0 and `err_clr` is ignored.

## Test plan
- All 4 channels valid continuously, `m_axis_tready`=1 -> frames granted in order ch0, ch1, ch2, ch3, ch0. Each frame has 255 bytes with tlast on the 255th; tuser matches the grant; 256 cycles per frame.
- Only ch2 requests, then ch1 joins mid-frame -> ch2 finishes 255 bytes uninterrupted, then ch1 is granted; `s_axis_tready[1]` stays 0 during the ch2 frame.
- Random `m_axis_tready` (50%) -> output data stays stable while stalled; per-channel byte sequences arrive in order without loss or duplication.
- Macro on, `TIMEOUT_CYC`=16: ch0 stops after 100 bytes -> after 16 stall cycles, 155 bytes of 0x00 with tlast, `err_pad`=1 until `err_clr`. Simultaneous set and clear leaves `err_pad`=1.
- Macro off, same stimulus -> no padding, grant held; resuming ch0 after 500 cycles completes the frame correctly.
- `rst_n` asserted at byte 40 of a frame -> all outputs 0 asynchronously. After release, ch0 is granted first and byte_cnt restarts at 0.
